mips_prog_loader: RTL and testbench
===================================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, width of the processor memory word address.
REQ-002 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 clk1  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_byte.
REQ-006 in_byte  input  8  stream byte.
REQ-007 in_ready  output  1  loader accepts a byte; a byte transfers when in_valid & in_ready are high at a clk1 edge.
REQ-008 mem_we  output  1  one-cycle write strobe to processor memory.
REQ-009 mem_addr  output  ADDR_W  memory word address.
REQ-010 mem_wdata  output  32  instruction/data word.
REQ-011 cpu_halt  output  1  holds the processor halted (drives HALTED) while high.
REQ-012 cpu_start  output  1  one-cycle pulse; processor clears PC and TAKEN_BRANCH and begins fetch.
REQ-013 load_done  output  1  last frame loaded with good checksum.
REQ-014 err  output  1  sticky checksum error.

Function
REQ-015 Frame: SYNC_BYTE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT words of 4 bytes each (MSB first), CHK.
REQ-016 States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR.
REQ-017 IDLE: accept bytes; SYNC_BYTE -> ADDR_HI, any other byte discarded, stay IDLE.
REQ-018 ADDR_HI/ADDR_LO capture 16-bit start address; low ADDR_W bits used, upper bits ignored but included in checksum.
REQ-019 CNT_HI/CNT_LO capture 16-bit word count; CNT=0 -> CHK directly from CNT_LO.
REQ-020 DATA: shift bytes into a 32-bit assembly register; on the 4th accepted byte of a word, assert mem_we for exactly the next cycle with the assembled word and current address.
REQ-021 Address increments by 1 after each write, modulo 2^ADDR_W (1023 -> 0 at default).
REQ-022 After the last word's 4th byte -> CHK; in_ready stays high in DATA, no stall.
REQ-023 Checksum: 8-bit XOR of every byte after SYNC_BYTE up to but excluding CHK.
REQ-024 CHK match -> DONE: cpu_start high one cycle, cpu_halt low, load_done high, err cleared.
REQ-025 CHK mismatch -> ERR: err high, cpu_halt high, load_done low, no cpu_start; words already written are not rolled back.
REQ-026 in_ready high in IDLE, ADDR_*, CNT_*, DATA, CHK; low in DONE and ERR.
REQ-027 DONE and ERR are terminal until rst; cpu_halt is high in every state except DONE.
REQ-028 in_valid low in any state: no state change, no output change.

Reset
REQ-029 rst asserted: state IDLE, in_ready 0 during reset, mem_we 0, mem_addr 0, mem_wdata 0, cpu_halt 1, cpu_start 0, load_done 0, err 0, checksum 0, byte counters 0.
REQ-030 rst mid-frame aborts the frame immediately; partial word never written; next frame needs fresh SYNC_BYTE.

Structure
REQ-031 State encoding, SYNC_BYTE default and ADDR_W default in shared package mips_loader_pkg.
REQ-032 One natural sub-module: loader_word_asm (byte shift register + byte-of-word counter + checksum XOR).

Verification
REQ-033 Frame addr 0x0000, CNT 11, words 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000, correct CHK -> 11 mem_we pulses, addr 0..10, same data, then cpu_start pulse, cpu_halt 0, load_done 1.
REQ-034 Same frame with CHK XOR 8'h01 -> 11 writes, err 1, cpu_start never pulses, cpu_halt 1, in_ready 0.
REQ-035 Addr 0x03FF, CNT 2, words 00000007, 00000001 -> writes at 1023 then 0.
REQ-036 Bytes 00, FF, 5A before SYNC_BYTE, then valid CNT 0 frame with CHK 0x03^0xFF=... computed XOR -> no writes, DONE reached, bytes before sync ignored.
REQ-037 rst asserted after 2 bytes of word 3 -> outputs to reset values same cycle; new frame loads correctly from its start address.
REQ-038 in_valid toggled randomly with 50% duty on REQ-033 frame -> identical writes and completion.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS program loader: state encoding and defaults.
package mips_loader_pkg;
  localparam int         ADDR_W_DEF    = 10;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
    S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler with byte-of-word counter and running XOR checksum.
module loader_word_asm (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift,
  input  logic        csum_en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last,
  output logic [7:0]  csum
);
  logic [23:0] sh;
  logic [1:0]  bcnt;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      bcnt <= '0;
      csum <= '0;
    end else if (clr) begin
      sh   <= '0;
      bcnt <= '0;
      csum <= '0;
    end else begin
      if (shift) begin
        sh   <= {sh[15:0], din};
        bcnt <= bcnt + 2'd1;
      end
      if (csum_en) csum <= csum ^ din;
    end
  end

  // word already includes the byte being accepted, so the write can launch on the 4th byte
  assign word = {sh, din};
  assign last = (bcnt == 2'd3);
endmodule

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: parses framed words into processor memory, then releases the CPU.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic              load_done,
  output logic              err
);
  state_t            state, nxt;
  logic              acc;
  logic [7:0]        addr_hi, cnt_hi;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       words_left;
  logic              asm_clr, asm_shift, asm_csum, asm_last;
  logic [31:0]       asm_word;
  logic [7:0]        csum;

  assign in_ready  = ~rst & (state != S_DONE) & (state != S_ERR);
  assign acc       = in_valid & in_ready;
  assign cpu_halt  = (state != S_DONE);
  assign load_done = (state == S_DONE);
  assign err       = (state == S_ERR);

  loader_word_asm u_asm (
    .clk1   (clk1),
    .rst    (rst),
    .clr    (asm_clr),
    .shift  (asm_shift),
    .csum_en(asm_csum),
    .din    (in_byte),
    .word   (asm_word),
    .last   (asm_last),
    .csum   (csum)
  );

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    asm_csum  = 1'b0;
    if (acc) begin
      case (state)
        S_IDLE:    if (in_byte == SYNC_BYTE) begin
                     nxt     = S_ADDR_HI;
                     asm_clr = 1'b1;
                   end
        S_ADDR_HI: begin nxt = S_ADDR_LO; asm_csum = 1'b1; end
        S_ADDR_LO: begin nxt = S_CNT_HI;  asm_csum = 1'b1; end
        S_CNT_HI:  begin nxt = S_CNT_LO;  asm_csum = 1'b1; end
        S_CNT_LO:  begin
                     asm_csum = 1'b1;
                     nxt      = ({cnt_hi, in_byte} == 16'd0) ? S_CHK : S_DATA;
                   end
        S_DATA:    begin
                     asm_csum  = 1'b1;
                     asm_shift = 1'b1;
                     if (asm_last && words_left == 16'd1) nxt = S_CHK;
                   end
        S_CHK:     nxt = (in_byte == csum) ? S_DONE : S_ERR;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      addr_hi    <= '0;
      cnt_hi     <= '0;
      waddr      <= '0;
      words_left <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_start  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      if (acc) begin
        case (state)
          S_ADDR_HI: addr_hi <= in_byte;
          // upper address bits beyond ADDR_W are dropped here but still fed the checksum
          S_ADDR_LO: waddr <= ADDR_W'({addr_hi, in_byte});
          S_CNT_HI:  cnt_hi <= in_byte;
          S_CNT_LO:  words_left <= {cnt_hi, in_byte};
          S_DATA:    if (asm_last) begin
                       mem_we     <= 1'b1;
                       mem_addr   <= waddr;
                       mem_wdata  <= asm_word;
                       waddr      <= waddr + ADDR_W'(1);
                       words_left <= words_left - 16'd1;
                     end
          S_CHK:     cpu_start <= (in_byte == csum);
          default:   ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mips_prog_loader.sv
// Randomized frame-level bench for mips_prog_loader against a queue-based reference.
module tb_mips_prog_loader;
  localparam int AW = 10;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready, mem_we, cpu_halt, cpu_start, load_done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  mips_prog_loader dut (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_halt(cpu_halt), .cpu_start(cpu_start), .load_done(load_done), .err(err)
  );

  always #5 clk1 = ~clk1;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] wr_a[$];
  logic [31:0]   wr_d[$];
  int            starts = 0;

  // write/start log, cleared while reset is held
  always @(negedge clk1) begin
    if (rst) begin
      wr_a.delete();
      wr_d.delete();
      starts = 0;
    end else begin
      if (mem_we) begin
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_wdata);
      end
      if (cpu_start) starts++;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bq_t mk_frame(logic [15:0] a, wq_t w, logic [7:0] flip);
    bq_t         q;
    logic [7:0]  x = 8'h00;
    logic [15:0] n = 16'(w.size());
    logic [31:0] wd;
    q.push_back(8'hA5);
    q.push_back(a[15:8]);
    q.push_back(a[7:0]);
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
    foreach (w[k]) begin
      wd = w[k];
      q.push_back(wd[31:24]);
      q.push_back(wd[23:16]);
      q.push_back(wd[15:8]);
      q.push_back(wd[7:0]);
    end
    for (int k = 1; k < q.size(); k++) x = x ^ q[k];
    q.push_back(x ^ flip);
    return q;
  endfunction

  task automatic send(bq_t q, int pct);
    int i = 0;
    int cyc = 0;
    while (i < q.size() && cyc < 4000) begin
      @(negedge clk1);
      cyc++;
      if (in_ready && $urandom_range(99) < pct) begin
        in_valid = 1'b1;
        in_byte  = q[i];
        i++;
      end else begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
      end
    end
    @(negedge clk1);
    in_valid = 1'b0;
    chk("send_timeout", i, q.size());
  endtask

  task automatic check_writes(string tag, logic [15:0] a, wq_t w);
    chk({tag, "_nwr"}, wr_a.size(), w.size());
    for (int k = 0; k < w.size() && k < wr_a.size(); k++) begin
      chk({tag, "_addr"}, wr_a[k], ((int'(a) % 1024) + k) % 1024);
      chk({tag, "_data"}, wr_d[k], w[k]);
    end
  endtask

  task automatic final_ok(string tag, bit good);
    chk({tag, "_starts"}, starts, good ? 1 : 0);
    chk({tag, "_halt"},   cpu_halt,  !good);
    chk({tag, "_done"},   load_done, good);
    chk({tag, "_err"},    err,       !good);
    chk({tag, "_ready"},  in_ready,  1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
  endtask

  initial begin
    wq_t         prog, wrap, none, rw, part;
    bq_t         f, p;
    logic [15:0] ra;
    bit          good;

    prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
             32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
             32'hfc000000};
    wrap = '{32'h00000007, 32'h00000001};

    repeat (2) @(negedge clk1);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_we",    mem_we,   1'b0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_halt",  cpu_halt, 1'b1);
    chk("rst_start", cpu_start, 1'b0);
    chk("rst_done",  load_done, 1'b0);
    chk("rst_err",   err, 1'b0);
    rst = 1'b0;

    // good program frame
    send(mk_frame(16'h0000, prog, 8'h00), 100);
    repeat (3) @(negedge clk1);
    check_writes("prog", 16'h0000, prog);
    final_ok("prog", 1'b1);

    // corrupted checksum
    do_reset();
    send(mk_frame(16'h0000, prog, 8'h01), 100);
    repeat (3) @(negedge clk1);
    check_writes("badchk", 16'h0000, prog);
    final_ok("badchk", 1'b0);

    // address wrap
    do_reset();
    send(mk_frame(16'h03FF, wrap, 8'h00), 100);
    repeat (3) @(negedge clk1);
    check_writes("wrap", 16'h03FF, wrap);
    final_ok("wrap", 1'b1);

    // junk before sync, zero-length frame
    do_reset();
    f = mk_frame(16'h03FF, none, 8'h00);
    f.push_front(8'h5A);
    f.push_front(8'hFF);
    f.push_front(8'h00);
    send(f, 100);
    repeat (3) @(negedge clk1);
    check_writes("cnt0", 16'h03FF, none);
    final_ok("cnt0", 1'b1);

    // reset mid-word, then a fresh frame
    do_reset();
    f = mk_frame(16'h0020, prog, 8'h00);
    for (int k = 0; k < 15; k++) p.push_back(f[k]);
    send(p, 100);
    repeat (2) @(negedge clk1);
    chk("mid_nwr", wr_a.size(), 2);
    rst = 1'b1;
    #1;
    chk("mid_ready", in_ready, 1'b0);
    chk("mid_we",    mem_we, 1'b0);
    chk("mid_addr",  mem_addr, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_halt",  cpu_halt, 1'b1);
    chk("mid_done",  load_done, 1'b0);
    @(negedge clk1);
    rst = 1'b0;
    part = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef};
    send(mk_frame(16'h0100, part, 8'h00), 100);
    repeat (3) @(negedge clk1);
    check_writes("mid_new", 16'h0100, part);
    final_ok("mid_new", 1'b1);

    // gappy valid on the program frame
    do_reset();
    send(mk_frame(16'h0000, prog, 8'h00), 50);
    repeat (3) @(negedge clk1);
    check_writes("gap", 16'h0000, prog);
    final_ok("gap", 1'b1);

    // random frames
    for (int r = 0; r < 4; r++) begin
      do_reset();
      rw.delete();
      ra = 16'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) rw.push_back($urandom);
      good = (r != 2);
      send(mk_frame(ra, rw, good ? 8'h00 : 8'(1 << $urandom_range(7))), $urandom_range(30, 100));
      repeat (3) @(negedge clk1);
      check_writes("rnd", ra, rw);
      final_ok("rnd", good);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
